// File: rtl/field_arith_pipe.sv
// Streaming prime-field unit: mul/add/sub/square mod PRIME. Results leave a
// fixed-latency pipeline in order through a credit-guarded FWFT output buffer.
module field_arith_pipe #(
  parameter int               NBITS      = 61,
  parameter logic [NBITS-1:0] PRIME      = 61'h1FFF_FFFF_FFFF_FFFF,
  parameter int               LATENCY    = 4,
  parameter int               TAG_BITS   = 8,
  parameter int               FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic [NBITS-1:0]    a,
  input  logic [NBITS-1:0]    b,
  input  logic [TAG_BITS-1:0] in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NBITS-1:0]    c,
  output logic [TAG_BITS-1:0] out_tag,
  output logic                out_err,
  output logic                idle
);
  localparam int W2 = 2 * NBITS;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [W2-1:0] PRIME_W = W2'(PRIME);

  logic                accept, pop, wr_en, in_err;
  logic [NBITS-1:0]    a_red, b_red, res;
  logic [W2-1:0]       raw_d;
  logic [CW-1:0]       cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic [PW-1:0]       wp_q, rp_q;
  logic [LATENCY:1]    vld_q, err_q;
  logic [W2-1:0]       raw_q [1:LATENCY];
  logic [TAG_BITS-1:0] tag_q [1:LATENCY];
  logic [NBITS-1:0]    mem_c_q   [FIFO_DEPTH];
  logic [TAG_BITS-1:0] mem_tag_q [FIFO_DEPTH];
  logic                mem_err_q [FIFO_DEPTH];

  // Square reuses the multiplier with b replaced by a; all raw values stay
  // 2*NBITS wide so the final reduction sees the untruncated product.
  always_comb begin
    a_red  = a % PRIME;
    b_red  = (op == 2'd3) ? a_red : b % PRIME;
    in_err = (a >= PRIME) || ((b >= PRIME) && (op != 2'd3));
    case (op)
      2'd1:    raw_d = W2'(a_red) + W2'(b_red);
      2'd2:    raw_d = W2'(a_red) + PRIME_W - W2'(b_red);
      default: raw_d = W2'(a_red) * W2'(b_red);
    endcase
  end

  assign in_ready  = (cnt_q < DEPTH_C) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (fcnt_q != '0) && !rst;
  assign pop       = out_valid && out_ready;
  assign idle      = (cnt_q == '0) || rst;
  assign wr_en     = vld_q[LATENCY];
  assign res       = NBITS'(raw_q[LATENCY] % PRIME_W);
  assign c         = out_valid ? mem_c_q[rp_q]   : '0;
  assign out_tag   = out_valid ? mem_tag_q[rp_q] : '0;
  assign out_err   = out_valid ? mem_err_q[rp_q] : 1'b0;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!accept && pop) cnt_d = cnt_q - CW'(1);
    fcnt_d = fcnt_q;
    if (wr_en && !pop)       fcnt_d = fcnt_q + CW'(1);
    else if (!wr_en && pop)  fcnt_d = fcnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      cnt_q  <= '0;
      fcnt_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      vld_q[1] <= accept;
      for (int s = 2; s <= LATENCY; s++) vld_q[s] <= vld_q[s-1];
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      if (wr_en) wp_q <= nxt(wp_q);
      if (pop)   rp_q <= nxt(rp_q);
    end
  end

  always_ff @(posedge clk) begin
    raw_q[1] <= raw_d;
    tag_q[1] <= in_tag;
    err_q[1] <= in_err;
    for (int s = 2; s <= LATENCY; s++) begin
      raw_q[s] <= raw_q[s-1];
      tag_q[s] <= tag_q[s-1];
      err_q[s] <= err_q[s-1];
    end
    if (wr_en) begin
      mem_c_q[wp_q]   <= res;
      mem_tag_q[wp_q] <= tag_q[LATENCY];
      mem_err_q[wp_q] <= err_q[LATENCY];
    end
  end

  // Credits make this unreachable; it guards against a broken credit count.
  always_ff @(posedge clk)
    if (!rst && wr_en) assert (fcnt_q != DEPTH_C);
endmodule

// File: tb/tb_field_arith_pipe.sv
// Scoreboard bench for field_arith_pipe: directed corner cases plus a random
// stream with random backpressure, checked against a plain arithmetic model.
module tb_field_arith_pipe;
  localparam int L = 4;
  localparam int D = 8;
  localparam logic [60:0] P = 61'h1FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]  op = '0;
  logic [60:0] a = '0, b = '0;
  logic [7:0]  in_tag = '0;
  logic        in_ready, out_valid, out_err, idle;
  logic [60:0] c;
  logic [7:0]  out_tag;

  typedef struct { logic [60:0] c; logic [7:0] tag; logic err; } exp_t;
  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks = 0, failures = 0, cyc = 0;
  bit   rnd_rdy = 1'b0;

  field_arith_pipe #(.NBITS(61), .PRIME(P), .LATENCY(L), .TAG_BITS(8), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .out_tag(out_tag), .out_err(out_err), .idle(idle));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [60:0] x, input logic [60:0] y,
                                 input logic [7:0] t);
    logic [127:0] xr, yr, r;
    exp_t e;
    xr = 128'(x) % 128'(P);
    yr = 128'(y) % 128'(P);
    case (o)
      2'd0: r = xr * yr;
      2'd1: r = xr + yr;
      2'd2: r = (xr >= yr) ? xr - yr : 128'(P) - (yr - xr);
      default: r = xr * xr;
    endcase
    e.c   = 61'(r % 128'(P));
    e.tag = t;
    e.err = (x >= P) || ((y >= P) && (o != 2'd3));
    return e;
  endfunction

  function automatic logic [60:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return P;
      1: return P - 61'd1;
      2: return '0;
      3: return 61'($urandom_range(0, 10));
      default: return 61'({$urandom(), $urandom()});
    endcase
  endfunction

  // Monitor: samples just before each rising edge, when a pop is about to happen.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual_c=%0h actual_tag=%0h expected=none", c, out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("result_c", 64'(c), 64'(e.c));
          chk("result_tag", 64'(out_tag), 64'(e.tag));
          chk("result_err", 64'(out_err), 64'(e.err));
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [60:0] x, input logic [60:0] y,
                       input logic [7:0] t);
    int n = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_tag = t; in_valid = 1'b1;
    #4;
    while (!in_ready && n < 1000) begin @(negedge clk); #4; n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_accept expected=accept tag=%0h", t);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(o, x, y, t));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Called right after an accept edge k with an empty pipe and buffer.
  task automatic check_latency(input string nm);
    repeat (L) @(negedge clk);
    #4 chk({nm, "_valid_before"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #4 chk({nm, "_valid_at"}, 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || !idle) && n < 500) begin @(negedge clk); #4; n++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("idle_after_drain", 64'(idle), 64'd1);
  endtask

  initial begin
    int acc, tg;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    @(negedge clk) rst = 1'b0;
    #4 chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Basic multiply and exact latency.
    issue(2'd0, 61'd3, 61'd5, 8'h11);
    check_latency("mul_latency");
    drain();

    // Wraparound cases back-to-back, popped on consecutive cycles.
    pop_cyc.delete();
    issue(2'd1, P - 61'd1, P - 61'd1, 8'h21);
    issue(2'd2, 61'd2, 61'd5, 8'h22);
    issue(2'd3, 61'h8000_0000, 61'd0, 8'h23);
    drain();
    chk("wrap_pops", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      chk("wrap_consec0", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      chk("wrap_consec1", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
    end

    // Non-canonical operands (PRIME is the only such 61-bit value).
    issue(2'd0, P, 61'd5, 8'h31);
    issue(2'd1, 61'd2, P, 8'h32);
    issue(2'd3, 61'd3, P, 8'h33);
    issue(2'd2, P - 61'd1, P, 8'h34);
    drain();

    // Backpressure: exactly D accepts with out_ready low.
    out_ready = 1'b0; acc = 0; tg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      op = 2'd0; a = 61'(tg + 1); b = 61'd7; in_tag = 8'(tg); in_valid = (tg < 12);
      #4;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op, a, b, in_tag));
        tg++; acc++;
      end
    end
    @(negedge clk) in_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'(D));
    #4 chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    #4 chk("bp_one_pop_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    while (tg < 12) begin issue(2'd0, 61'(tg + 1), 61'd7, 8'(tg)); tg++; end
    drain();

    // Random stream with random backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 8'($urandom));
    end
    @(negedge clk) rnd_rdy = 1'b0;
    drain();

    // Reset with 2 results buffered and 3 in flight.
    out_ready = 1'b0;
    issue(2'd1, 61'd1, 61'd1, 8'h41);
    issue(2'd1, 61'd2, 61'd2, 8'h42);
    repeat (L + 1) @(negedge clk);
    issue(2'd0, 61'd3, 61'd3, 8'h43);
    issue(2'd0, 61'd4, 61'd4, 8'h44);
    issue(2'd0, 61'd5, 61'd5, 8'h45);
    @(negedge clk) rst = 1'b1;
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    #4;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_idle", 64'(idle), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #4 chk("midrst_no_output", 64'(out_valid), 64'd0);
    end
    issue(2'd0, 61'd6, 61'd7, 8'h46);
    check_latency("post_rst_latency");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
